uart_cmd_decoder: RTL and testbench

//  Converts ASCII bytes from uart_rx (rx_data/rx_valid) into single-cycle command pulses
//  (uart_0..3, Q, F, R, W, S, A, D) consumed by command_controller.

---
 rtl/uart_cmd_decoder.sv | 146 ++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: byte FIFO + paced decoder turning ASCII bytes into command pulses.
// Ports: clk/rst, rx_data/rx_valid in, tx_busy in, tx_start/tx_data echo out,
// uart_0..3/Q/F/R/W/S/A/D pulses, cmd_err, fifo_ovf.
module uart_cmd_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 4,
  parameter bit ECHO_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       uart_0,
  output logic       uart_1,
  output logic       uart_2,
  output logic       uart_3,
  output logic       uart_Q,
  output logic       uart_F,
  output logic       uart_R,
  output logic       uart_W,
  output logic       uart_S,
  output logic       uart_A,
  output logic       uart_D,
  output logic       cmd_err,
  output logic       fifo_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    ECHO_WAIT,
    ECHO_SEND,
    GAP
  } state_t;

  state_t state, state_n;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  logic [7:0]    byte_q;
  logic [11:0]   dec_q;
  logic [11:0]   pulses;
  logic [GW-1:0] gap_cnt;
  logic          gap_done, recognised;

  // Bit k of the result: 0..3 digits, 4..10 Q F R W S A D, 11 error.
  // CR/LF decode to all zeros.
  function automatic logic [11:0] decode(input logic [7:0] b);
    logic [7:0] u;
    u = b;
    if (b >= 8'h61 && b <= 8'h7a) u = b - 8'h20;
    decode = '0;
    case (u)
      8'h30:   decode[0]  = 1'b1;
      8'h31:   decode[1]  = 1'b1;
      8'h32:   decode[2]  = 1'b1;
      8'h33:   decode[3]  = 1'b1;
      8'h51:   decode[4]  = 1'b1;
      8'h46:   decode[5]  = 1'b1;
      8'h52:   decode[6]  = 1'b1;
      8'h57:   decode[7]  = 1'b1;
      8'h53:   decode[8]  = 1'b1;
      8'h41:   decode[9]  = 1'b1;
      8'h44:   decode[10] = 1'b1;
      8'h0d,
      8'h0a:   decode     = '0;
      default: decode[11] = 1'b1;
    endcase
  endfunction

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = (state == IDLE) && !empty;
  // A full FIFO still takes a byte when a pop frees a slot this cycle.
  assign push     = rx_valid && (!full || pop);
  assign fifo_ovf = rx_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      byte_q  <= '0;
      dec_q   <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_n;
      if (pop) begin
        byte_q <= mem[rd_ptr];
        dec_q  <= decode(mem[rd_ptr]);
      end
      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
    end
  end

  assign gap_done   = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign recognised = |dec_q[10:0];

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (!empty) state_n = DECODE;
      DECODE:    state_n = (ECHO_EN && recognised) ? ECHO_WAIT : GAP;
      ECHO_WAIT: if (!tx_busy) state_n = ECHO_SEND;
      ECHO_SEND: state_n = GAP;
      GAP:       if (gap_done) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  assign pulses   = (state == DECODE) ? dec_q : '0;
  assign tx_start = (state == ECHO_SEND);
  assign tx_data  = byte_q;

  assign {cmd_err, uart_D, uart_A, uart_S, uart_W, uart_R, uart_F,
          uart_Q, uart_3, uart_2, uart_1, uart_0} = pulses;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed bench with a queue/timestamp model of the decoder.
// Two DUTs share stimulus: echo enabled (index 0) and echo disabled (index 1).
module tb_uart_cmd_decoder;

  localparam int G = 4;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic tx_busy = 1'b0;

  logic [1:0]       tx_start;
  logic [1:0][7:0]  txd;
  logic [1:0][11:0] pv;
  logic [1:0]       ovf;

  uart_cmd_decoder #(.FIFO_DEPTH(D), .GAP_CYCLES(G), .ECHO_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_start(tx_start[0]), .tx_data(txd[0]),
    .uart_0(pv[0][0]), .uart_1(pv[0][1]), .uart_2(pv[0][2]),
    .uart_3(pv[0][3]), .uart_Q(pv[0][4]), .uart_F(pv[0][5]),
    .uart_R(pv[0][6]), .uart_W(pv[0][7]), .uart_S(pv[0][8]),
    .uart_A(pv[0][9]), .uart_D(pv[0][10]), .cmd_err(pv[0][11]),
    .fifo_ovf(ovf[0])
  );

  uart_cmd_decoder #(.FIFO_DEPTH(D), .GAP_CYCLES(G), .ECHO_EN(1'b0)) dut_ne (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_start(tx_start[1]), .tx_data(txd[1]),
    .uart_0(pv[1][0]), .uart_1(pv[1][1]), .uart_2(pv[1][2]),
    .uart_3(pv[1][3]), .uart_Q(pv[1][4]), .uart_F(pv[1][5]),
    .uart_R(pv[1][6]), .uart_W(pv[1][7]), .uart_S(pv[1][8]),
    .uart_A(pv[1][9]), .uart_D(pv[1][10]), .cmd_err(pv[1][11]),
    .fifo_ovf(ovf[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, got, exp);
    end
  endtask

  // Model: byte queue plus the cycle at which the consumer may next pop.
  logic [7:0]  mbuf [2][64];
  int          mh [2] = '{0, 0};
  int          mt [2] = '{0, 0};
  int          ready [2] = '{0, 0};
  bit          waiting [2] = '{0, 0};
  int          wait_from [2] = '{0, 0};
  int          pp_cyc [2] = '{-1, -1};
  logic [11:0] pp_vec [2];
  int          ptx_cyc [2] = '{-1, -1};
  logic [7:0]  ptx_data [2];

  function automatic logic [11:0] classify(input logic [7:0] b);
    string cmds;
    logic [7:0] u;
    logic [11:0] r;
    cmds = "0123QFRWSAD";
    u = b;
    if (u >= 8'h61 && u <= 8'h7a) u = u - 8'h20;
    r = '0;
    if (u == 8'h0d || u == 8'h0a) return r;
    for (int k = 0; k < 11; k++)
      if (u == cmds[k]) r[k] = 1'b1;
    if (r == '0) r[11] = 1'b1;
    return r;
  endfunction

  task automatic model_step(input int i);
    logic [11:0] ev;
    logic [11:0] v;
    logic [7:0]  b;
    logic [7:0]  etd;
    bit et, eo, popping, ok;
    int c;
    c = cyc;
    if (rst) begin
      ev = '0; et = 0; eo = 0; etd = '0;
      mh[i] = 0; mt[i] = 0; ready[i] = 0; waiting[i] = 0;
      pp_cyc[i] = -1; ptx_cyc[i] = -1;
    end else begin
      ev = (pp_cyc[i] == c) ? pp_vec[i] : '0;
      et = (ptx_cyc[i] == c);
      etd = ptx_data[i];
      if (waiting[i] && c >= wait_from[i] && !tx_busy) begin
        ptx_cyc[i] = c + 1;
        ready[i] = c + 2 + G;
        waiting[i] = 0;
      end
      popping = !waiting[i] && c >= ready[i] && (mt[i] - mh[i]) > 0;
      if (popping) begin
        b = mbuf[i][mh[i] % 64];
        mh[i]++;
        v = classify(b);
        pp_cyc[i] = c + 1;
        pp_vec[i] = v;
        if (i == 0 && (|v[10:0])) begin
          waiting[i] = 1;
          wait_from[i] = c + 2;
          ptx_data[i] = b;
        end else begin
          ready[i] = c + 2 + G;
        end
      end
      eo = rx_valid && (mt[i] - mh[i]) == D;
      if (rx_valid && !eo) begin
        mbuf[i][mt[i] % 64] = rx_data;
        mt[i]++;
      end
    end
    ok = (pv[i] === ev) && (tx_start[i] === et) && (ovf[i] === eo);
    if (rst) ok = ok && (txd[i] === 8'h00);
    else if (et) ok = ok && (txd[i] === etd);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL model[%0d] cycle %0d: pulses=%h start=%b ovf=%b txd=%h want pulses=%h start=%b ovf=%b txd=%h",
               i, c, pv[i], tx_start[i], ovf[i], txd[i], ev, et, eo,
               rst ? 8'h00 : etd);
    end
  endtask

  int pulse_cnt0 = 0;
  int tx_cnt0 = 0;
  int d_cnt = 0;
  bit rec = 0;
  int w_cyc[$];
  int o_cyc[$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    if (pv[0] != '0) pulse_cnt0++;
    if (tx_start[0]) tx_cnt0++;
    if (pv[0][10]) d_cnt++;
    if (rec) begin
      if (pv[1][7]) w_cyc.push_back(cyc);
      if (ovf[1]) o_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic at(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  initial begin
    int n, s, f, m;
    repeat (3) tick();
    chk("rst_pulses", pv[0], 0);
    chk("rst_txd", txd[0], 0);
    chk("rst_start", tx_start[0], 0);
    rst = 1'b0;
    repeat (2) tick();

    // T1: 'q' then 'W' queued behind it
    n = cyc;
    send(8'h71);
    send(8'h57);
    at(n + 2);
    chk("t1_uart_q", pv[0], 12'h010);
    at(n + 3);
    chk("t1_no_start_early", tx_start[0], 0);
    at(n + 4);
    chk("t1_tx_start", tx_start[0], 1);
    chk("t1_tx_data", txd[0], 8'h71);
    at(n + 9);
    chk("t1_no_pop_in_gap", pv[0], 12'h000);
    at(n + 10);
    chk("t1_next_w", pv[0], 12'h080);
    repeat (30) tick();

    // T2: '2' then 'x'
    tx_cnt0 = 0;
    n = cyc;
    send(8'h32);
    send(8'h78);
    at(n + 2);
    chk("t2_uart_2", pv[0], 12'h004);
    at(n + 4);
    chk("t2_tx_data", txd[0], 8'h32);
    at(n + 10);
    chk("t2_cmd_err", pv[0], 12'h800);
    repeat (20) tick();
    chk("t2_tx_count", tx_cnt0, 1);

    // T5: CR, LF
    pulse_cnt0 = 0;
    tx_cnt0 = 0;
    send(8'h0d);
    send(8'h0a);
    repeat (30) tick();
    chk("t5_pulses", pulse_cnt0, 0);
    chk("t5_tx", tx_cnt0, 0);

    // T3: 12 back-to-back 'W'
    w_cyc.delete();
    o_cyc.delete();
    rec = 1;
    s = cyc;
    repeat (12) send(8'h57);
    repeat (80) tick();
    rec = 0;
    chk("t3_w_count", w_cyc.size(), 10);
    chk("t3_w_first", (w_cyc.size() > 0) ? w_cyc[0] : -1, s + 2);
    chk("t3_w_spacing", (w_cyc.size() > 1) ? w_cyc[1] - w_cyc[0] : -1, 6);
    chk("t3_w_last", (w_cyc.size() > 9) ? w_cyc[9] : -1, s + 56);
    chk("t3_ovf_count", o_cyc.size(), 2);
    chk("t3_ovf_0", (o_cyc.size() > 0) ? o_cyc[0] : -1, s + 10);
    chk("t3_ovf_1", (o_cyc.size() > 1) ? o_cyc[1] : -1, s + 11);
    repeat (60) tick();

    // T4: echo stalled by tx_busy
    tx_busy = 1'b1;
    d_cnt = 0;
    send(8'h41);
    send(8'h44);
    repeat (48) tick();
    chk("t4_no_d", d_cnt, 0);
    tx_busy = 1'b0;
    f = cyc;
    at(f + 1);
    chk("t4_tx_start", tx_start[0], 1);
    chk("t4_tx_data", txd[0], 8'h41);
    at(f + 7);
    chk("t4_uart_d", pv[0], 12'h400);
    repeat (20) tick();

    // T6: reset during GAP with three bytes queued
    n = cyc;
    send(8'h53);
    send(8'h31);
    send(8'h51);
    send(8'h7a);
    tick();
    tick();
    rst = 1'b1;
    at(n + 7);
    chk("t6_rst_pulses", pv[0], 0);
    chk("t6_rst_txd", txd[0], 0);
    tick();
    rst = 1'b0;
    pulse_cnt0 = 0;
    repeat (10) tick();
    chk("t6_no_stale", pulse_cnt0, 0);
    m = cyc;
    send(8'h46);
    at(m + 2);
    chk("t6_uart_f", pv[0], 12'h020);
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
